seq_divider32by16: RTL and testbench

//  Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor -> DW-bit quotient + DW-bit remainder.

---
 rtl/seq_divider32by16.sv | 180 ++++++++++++++++++
 tb/tb_seq_divider32by16.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider32by16.sv
// Sequential restoring divider, 2*DW / DW -> DW quotient + DW remainder.
// Define DIVIDER_SIGNED_EN for two's complement operands (adds a FIXUP cycle).
`timescale 1ns/1ps
module seq_divider32by16 #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int CW = $clog2(DW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RUN,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [2*DW-1:0] r_dvd;
  logic [DW-1:0]   r_dvs;
  logic [DW-1:0]   r_rem;
  logic [DW-1:0]   r_lo;
  logic [DW-1:0]   r_q;
  logic [CW-1:0]   r_cnt;
  logic            r_dz;
  logic            r_ov;

  logic [DW:0]     w_shift;
  logic            w_ge;
  logic [DW-1:0]   w_diff;
  logic [DW-1:0]   w_hi;
  logic [DW-1:0]   w_lo;
  logic [DW-1:0]   w_dvs;

  assign w_shift = {r_rem, r_lo[DW-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  // Result of a taken subtract is below the divisor, so DW bits suffice
  assign w_diff  = w_shift[DW-1:0] - r_dvs;

`ifdef DIVIDER_SIGNED_EN
  localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_MAX = {1'b1, {(DW-1){1'b0}}};

  logic [2*DW-1:0] w_mag_dvd;
  logic            r_neg;
  logic            r_big;

  assign w_mag_dvd = r_dvd[2*DW-1] ? ({(2*DW){1'b0}} - r_dvd) : r_dvd;
  assign w_dvs     = r_dvs[DW-1] ? ({DW{1'b0}} - r_dvs) : r_dvs;
  assign w_hi      = w_mag_dvd[2*DW-1:DW];
  assign w_lo      = w_mag_dvd[DW-1:0];
`else
  assign w_dvs = r_dvs;
  assign w_hi  = r_dvd[2*DW-1:DW];
  assign w_lo  = r_dvd[DW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_lo        <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_dz        <= 1'b0;
      r_ov        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      r_neg       <= 1'b0;
      r_big       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      busy <= 1'b1;
      case (r_state)
        S_IDLE: begin
          busy <= 1'b0;
          // The done cycle still counts as busy, so start is ignored there
          if (start && !done) begin
            r_dvd   <= dividend;
            r_dvs   <= divisor;
            r_dz    <= 1'b0;
            r_ov    <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_CHECK;
`ifdef DIVIDER_SIGNED_EN
            r_big   <= 1'b0;
`endif
          end
        end
        S_CHECK: begin
          r_rem <= w_hi;
          r_lo  <= w_lo;
          r_dvs <= w_dvs;
`ifdef DIVIDER_SIGNED_EN
          r_neg <= r_dvd[2*DW-1] ^ r_dvs[DW-1];
`endif
          if (r_dvs == '0) begin
            r_dz    <= 1'b1;
            r_q     <= '1;
            r_rem   <= r_dvd[DW-1:0];
            r_state <= S_DONE;
          end else if (w_hi >= w_dvs) begin
`ifdef DIVIDER_SIGNED_EN
            r_big   <= 1'b1;
            r_state <= S_FIXUP;
`else
            r_ov    <= 1'b1;
            r_q     <= '1;
            r_rem   <= r_dvd[DW-1:0];
            r_state <= S_DONE;
`endif
          end else begin
            r_cnt   <= CW'(DW-1);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_rem <= w_ge ? w_diff : w_shift[DW-1:0];
          r_lo  <= {r_lo[DW-2:0], 1'b0};
          r_q   <= {r_q[DW-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
`ifdef DIVIDER_SIGNED_EN
            r_state <= S_FIXUP;
`else
            r_state <= S_DONE;
`endif
          end
        end
`ifdef DIVIDER_SIGNED_EN
        S_FIXUP: begin
          if (r_big || (!r_neg && r_q > POS_MAX) ||
              (r_neg && r_q > NEG_MAX)) begin
            r_ov  <= 1'b1;
            r_q   <= '1;
            r_rem <= r_dvd[DW-1:0];
          end else begin
            r_q   <= r_neg ? ({DW{1'b0}} - r_q) : r_q;
            r_rem <= r_dvd[2*DW-1] ? ({DW{1'b0}} - r_rem) : r_rem;
          end
          r_state <= S_DONE;
        end
`endif
        S_DONE: begin
          done        <= 1'b1;
          quotient    <= r_q;
          remainder   <= r_rem;
          div_by_zero <= r_dz;
          overflow    <= r_ov;
          r_state     <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider32by16.sv
// Directed self-checking bench for seq_divider32by16.
// Signed vectors run only when DIVIDER_SIGNED_EN is defined.
`timescale 1ns/1ps
module tb_seq_divider32by16;

`ifdef DIVIDER_SIGNED_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 18;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int n_checks = 0;
  int n_errs = 0;

  always #5 clk = ~clk;

  seq_divider32by16 #(.DW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // lat == 0 means the completion cycle is not pinned down
  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [15:0] b, input int lat,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edz, input logic eov);
    int n;
    n = 0;
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, ".busy_acc"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 30 && n == 0; i++) begin
      @(posedge clk);
      #1;
      if (done) n = i;
    end
    if (lat > 0) chk({tag, ".lat"}, n, lat);
    else chk({tag, ".seen"}, {31'd0, n != 0}, 32'd1);
    chk({tag, ".q"}, {16'd0, quotient}, {16'd0, eq});
    chk({tag, ".r"}, {16'd0, remainder}, {16'd0, er});
    chk({tag, ".dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    chk({tag, ".ov"}, {31'd0, overflow}, {31'd0, eov});
    chk({tag, ".busy_done"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk({tag, ".done_clr"}, {31'd0, done}, 32'd0);
    chk({tag, ".busy_clr"}, {31'd0, busy}, 32'd0);
    chk({tag, ".q_hold"}, {16'd0, quotient}, {16'd0, eq});
  endtask

  initial begin
    int nd;
    int p1;
    int p2;
    logic [15:0] q1;
    logic [15:0] q2;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.q", {16'd0, quotient}, 32'd0);
    chk("rst.r", {16'd0, remainder}, 32'd0);
    chk("rst.dz", {31'd0, div_by_zero}, 32'd0);
    chk("rst.ov", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t1", 32'h0000_0064, 16'h0007, LAT, 16'h000E, 16'h0002, 0, 0);
    run_op("t3", 32'h1234_5678, 16'h0000, 2, 16'hFFFF, 16'h5678, 1, 0);
    run_op("inv", 32'h1234_5678, 16'h5678, LAT, 16'h35E5, 16'h2520, 0, 0);
`ifdef DIVIDER_SIGNED_EN
    run_op("t6a", 32'hFFFF_FF9C, 16'h0007, 19, 16'hFFF2, 16'hFFFE, 0, 0);
    run_op("t6b", 32'h0000_0064, 16'hFFF9, 19, 16'hFFF2, 16'h0002, 0, 0);
    run_op("t6c", 32'h8000_0000, 16'hFFFF, 0, 16'hFFFF, 16'h0000, 0, 1);
    run_op("t6d", 32'hFFFF_8000, 16'h0001, 19, 16'h8000, 16'h0000, 0, 0);
    run_op("t6e", 32'h0000_8000, 16'h0001, 0, 16'hFFFF, 16'h0000, 0, 1);
`else
    run_op("t2a", 32'hFFFE_0001, 16'hFFFF, 18, 16'hFFFF, 16'h0000, 0, 0);
    run_op("t2b", 32'h0001_0000, 16'h0001, 2, 16'hFFFF, 16'h0000, 0, 1);
    run_op("t2c", 32'h0000_0000, 16'h0001, 18, 16'h0000, 16'h0000, 0, 0);
`endif

    // start held high across a whole op and beyond
    nd = 0;
    p1 = 0;
    p2 = 0;
    q1 = '0;
    q2 = '0;
    @(negedge clk);
    start = 1'b1;
    dividend = 32'h0000_0064;
    divisor = 16'h0007;
    @(posedge clk);
    for (int i = 1; i <= 2 * LAT + 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        dividend = 32'h1234_5678;
        divisor = 16'h5678;
      end
      if (done) begin
        nd++;
        if (nd == 1) begin
          p1 = i;
          q1 = quotient;
        end else begin
          p2 = i;
          q2 = quotient;
        end
      end
      if (i == LAT + 2) start = 1'b0;
    end
    chk("t4.ndone", nd, 2);
    chk("t4.pos1", p1, LAT);
    chk("t4.pos2", p2, 2 * LAT + 2);
    chk("t4.q1", {16'd0, q1}, 32'h0000_000E);
    chk("t4.q2", {16'd0, q2}, 32'h0000_35E5);

    // reset in the middle of a running op
    @(negedge clk);
    start = 1'b1;
    dividend = 32'h0000_0064;
    divisor = 16'h0007;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5.busy", {31'd0, busy}, 32'd0);
    chk("t5.done", {31'd0, done}, 32'd0);
    chk("t5.q", {16'd0, quotient}, 32'd0);
    chk("t5.r", {16'd0, remainder}, 32'd0);
    chk("t5.dz", {31'd0, div_by_zero}, 32'd0);
    chk("t5.ov", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("t5.nodone", nd, 0);
    run_op("t5b", 32'h0000_0064, 16'h0007, LAT, 16'h000E, 16'h0002, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
